// File: rtl/inst_pool.sv
// Instruction pool: DEPTH-entry circular buffer between decode and scheduler.
// Presents the oldest WIN entries per cycle and retires 0..WIN in order.
module inst_pool #(
    parameter int DEPTH = 8,
    parameter int WIN = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int IW = $clog2(WIN + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              STALL,
    input  logic              MMU_WAIT,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [31:0]       PC,
    input  logic [16:0]       OPCODE,
    input  logic [4:0]        RD,
    input  logic [4:0]        RS1,
    input  logic [4:0]        RS2,
    input  logic [31:0]       RINST,
    input  logic [IW-1:0]     ISSUE_NUM,
    output logic [WIN-1:0]    POOL_VALID,
    output logic [32*WIN-1:0] POOL_PC,
    output logic [17*WIN-1:0] POOL_OPCODE,
    output logic [5*WIN-1:0]  POOL_RD,
    output logic [5*WIN-1:0]  POOL_RS1,
    output logic [5*WIN-1:0]  POOL_RS2,
    output logic [32*WIN-1:0] POOL_RINST,
    output logic [CW-1:0]     COUNT
);

    typedef struct packed {
        logic [31:0] pc;
        logic [16:0] op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] ri;
    } entry_t;

    localparam entry_t NOP = '{
        pc:  32'h0,
        op:  {7'b0010011, 3'b000, 7'b0000000},
        rd:  5'd0,
        rs1: 5'd0,
        rs2: 5'd0,
        ri:  32'h0000_0013
    };

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          hold;
    logic          push;
    logic [CW-1:0] req;
    logic [CW-1:0] lim;
    logic [CW-1:0] pop_n;

    // Readiness looks only at registered count, never at ISSUE_NUM.
    always_comb begin
        hold     = STALL | MMU_WAIT;
        IN_READY = (count_q != CW'(DEPTH));
        push     = IN_VALID & IN_READY & ~hold & ~RST & ~FLUSH;
        req      = CW'(ISSUE_NUM);
        lim      = (count_q < CW'(WIN)) ? count_q : CW'(WIN);
        pop_n    = '0;
        if (!hold && !RST && !FLUSH) begin
            pop_n = (req < lim) ? req : lim;
        end
        head_d  = head_q + AW'(pop_n);
        tail_d  = tail_q + AW'(push);
        count_d = count_q + CW'(push) - pop_n;
    end

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[tail_q] <= '{
                pc: PC, op: OPCODE, rd: RD,
                rs1: RS1, rs2: RS2, ri: RINST
            };
        end
    end

    for (genvar i = 0; i < WIN; i++) begin : g_slot
        logic [AW-1:0] idx;
        logic          v;
        entry_t        e;
        assign idx = head_q + AW'(i);
        assign v   = (CW'(i) < count_q);
        assign e   = v ? mem_q[idx] : NOP;
        assign POOL_VALID[i]           = v;
        assign POOL_PC[32*i +: 32]     = e.pc;
        assign POOL_OPCODE[17*i +: 17] = e.op;
        assign POOL_RD[5*i +: 5]       = e.rd;
        assign POOL_RS1[5*i +: 5]      = e.rs1;
        assign POOL_RS2[5*i +: 5]      = e.rs2;
        assign POOL_RINST[32*i +: 32]  = e.ri;
    end

    assign COUNT = count_q;

endmodule

// File: tb/tb_inst_pool.sv
// Randomized and directed bench for inst_pool against a queue-based model.
module tb_inst_pool;
    localparam int DEPTH = 8;
    localparam int WIN = 2;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(WIN + 1);

    logic              CLK = 1'b0;
    logic              RST, FLUSH, STALL, MMU_WAIT, IN_VALID, IN_READY;
    logic [31:0]       PC, RINST;
    logic [16:0]       OPCODE;
    logic [4:0]        RD, RS1, RS2;
    logic [IW-1:0]     ISSUE_NUM;
    logic [WIN-1:0]    POOL_VALID;
    logic [32*WIN-1:0] POOL_PC, POOL_RINST;
    logic [17*WIN-1:0] POOL_OPCODE;
    logic [5*WIN-1:0]  POOL_RD, POOL_RS1, POOL_RS2;
    logic [CW-1:0]     COUNT;

    always #5 CLK = ~CLK;

    inst_pool #(.DEPTH(DEPTH), .WIN(WIN)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(STALL),
        .MMU_WAIT(MMU_WAIT), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .PC(PC), .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2),
        .RINST(RINST), .ISSUE_NUM(ISSUE_NUM), .POOL_VALID(POOL_VALID),
        .POOL_PC(POOL_PC), .POOL_OPCODE(POOL_OPCODE), .POOL_RD(POOL_RD),
        .POOL_RS1(POOL_RS1), .POOL_RS2(POOL_RS2),
        .POOL_RINST(POOL_RINST), .COUNT(COUNT)
    );

    typedef struct {
        logic [31:0] pc;
        logic [16:0] op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] ri;
    } ins_t;

    localparam logic [16:0] NOP_OP = {7'b0010011, 3'b000, 7'b0000000};

    ins_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic set_in(logic v, logic [31:0] pc, int iss);
        IN_VALID  = v;
        PC        = pc;
        OPCODE    = 17'($urandom);
        RD        = 5'($urandom);
        RS1       = 5'($urandom);
        RS2       = 5'($urandom);
        RINST     = $urandom;
        ISSUE_NUM = IW'(iss);
    endtask

    task automatic check_outputs();
        ins_t e;
        logic v;
        check("count", 32'(COUNT), 32'(q.size()));
        check("ready", 32'(IN_READY), 32'(q.size() != DEPTH));
        for (int i = 0; i < WIN; i++) begin
            v = (i < q.size());
            if (v) e = q[i];
            else e = '{pc: 0, op: NOP_OP, rd: 0, rs1: 0, rs2: 0, ri: 32'h13};
            check($sformatf("valid%0d", i), 32'(POOL_VALID[i]), 32'(v));
            check($sformatf("pc%0d", i), POOL_PC[32*i +: 32], e.pc);
            check($sformatf("op%0d", i), 32'(POOL_OPCODE[17*i +: 17]), 32'(e.op));
            check($sformatf("rd%0d", i), 32'(POOL_RD[5*i +: 5]), 32'(e.rd));
            check($sformatf("rs1_%0d", i), 32'(POOL_RS1[5*i +: 5]), 32'(e.rs1));
            check($sformatf("rs2_%0d", i), 32'(POOL_RS2[5*i +: 5]), 32'(e.rs2));
            check($sformatf("ri%0d", i), POOL_RINST[32*i +: 32], e.ri);
        end
    endtask

    // One clock: check window at negedge, advance model, cross posedge.
    task automatic cyc();
        int n;
        bit ready;
        @(negedge CLK);
        check_outputs();
        if (RST || FLUSH) begin
            q.delete();
        end else if (!(STALL || MMU_WAIT)) begin
            ready = (q.size() != DEPTH);
            n = int'(ISSUE_NUM);
            if (n > q.size()) n = q.size();
            if (n > WIN) n = WIN;
            repeat (n) void'(q.pop_front());
            if (IN_VALID && ready)
                q.push_back('{pc: PC, op: OPCODE, rd: RD, rs1: RS1,
                              rs2: RS2, ri: RINST});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic clear();
        FLUSH = 1'b1;
        set_in(1'b0, 0, 0);
        cyc();
        FLUSH = 1'b0;
    endtask

    task automatic fill(int n, logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            set_in(1'b1, base + 32'(4 * k), 0);
            cyc();
        end
        set_in(1'b0, 0, 0);
    endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0; STALL = 1'b0; MMU_WAIT = 1'b0;
        set_in(1'b0, 0, 0);
        cyc();
        RST = 1'b0;
        check("rst_count", 32'(COUNT), 0);
        check("rst_ready", 32'(IN_READY), 1);
        check("rst_valid", 32'(POOL_VALID), 0);

        // Fill to capacity; the ninth offer is refused.
        fill(9, 32'h100);
        check("full_count", 32'(COUNT), 8);
        check("full_ready", 32'(IN_READY), 0);
        check("full_pc0", POOL_PC[31:0], 32'h100);
        check("full_pc1", POOL_PC[63:32], 32'h104);

        // Full with simultaneous issue: pop 2, no push, then push+pop 2.
        set_in(1'b1, 32'h300, 2);
        cyc();
        check("fi_count", 32'(COUNT), 6);
        check("fi_pc0", POOL_PC[31:0], 32'h108);
        set_in(1'b1, 32'h304, 2);
        cyc();
        check("fi_count2", 32'(COUNT), 5);

        // Wrap-around with push and issue of one per cycle.
        clear();
        fill(1, 32'h400);
        for (int k = 1; k <= 20; k++) begin
            set_in(1'b1, 32'h400 + 32'(4 * k), 1);
            cyc();
            check("wrap_pc0", POOL_PC[31:0], 32'h400 + 32'(4 * k));
        end

        // Single live entry: NOP fill on slot 1, then clamped issue.
        clear();
        fill(1, 32'h200);
        check("nop_valid", 32'(POOL_VALID), 32'b01);
        check("nop_op1", 32'(POOL_OPCODE[33:17]), 32'(NOP_OP));
        check("nop_ri1", POOL_RINST[63:32], 32'h13);
        check("nop_pc1", POOL_PC[63:32], 0);
        set_in(1'b0, 0, 2);
        cyc();
        check("clamp_count", 32'(COUNT), 0);

        // Stall, then MMU wait, with issue and input pending.
        clear();
        fill(3, 32'h500);
        for (int m = 0; m < 2; m++) begin
            STALL = (m == 0);
            MMU_WAIT = (m == 1);
            for (int k = 0; k < 4; k++) begin
                set_in(1'b1, 32'h600, 2);
                cyc();
            end
            check("stall_count", 32'(COUNT), 3);
            check("stall_pc0", POOL_PC[31:0], 32'h500);
        end
        STALL = 1'b0; MMU_WAIT = 1'b0;

        // Flush while pushing and issuing.
        fill(2, 32'h700);
        FLUSH = 1'b1;
        set_in(1'b1, 32'h800, 1);
        cyc();
        FLUSH = 1'b0;
        check("fl_count", 32'(COUNT), 0);
        check("fl_valid", 32'(POOL_VALID), 0);
        check("fl_ready", 32'(IN_READY), 1);
        fill(1, 32'h900);
        check("fl_pc0", POOL_PC[31:0], 32'h900);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            RST = ($urandom_range(0, 299) == 0);
            FLUSH = ($urandom_range(0, 99) == 0);
            STALL = ($urandom_range(0, 9) == 0);
            MMU_WAIT = ($urandom_range(0, 9) == 0);
            set_in(1'($urandom_range(0, 3) != 0), $urandom,
                   int'($urandom_range(0, (1 << IW) - 1)));
            cyc();
        end
        RST = 1'b0; FLUSH = 1'b0; STALL = 1'b0; MMU_WAIT = 1'b0;
        set_in(1'b0, 0, 0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
